// File: rtl/uart_pkg.sv
// Shared types and helpers for the buffered UART transmit path.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        LAUNCH    = 2'd1,
        WAIT_DONE = 2'd2
    } tx_fifo_state_t;

    // Pointer width for a power-of-two FIFO depth; never narrower than one bit.
    function automatic int ptr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/uart_fifo_mem.sv
// Dual-pointer FIFO storage with a registered occupancy count.
// Pointers wrap naturally; the storage array itself is not reset.
module uart_fifo_mem
    import uart_pkg::*;
#(
    parameter int DATA_BITS = 8,
    parameter int DEPTH     = 16
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         wr_en,
    input  logic [DATA_BITS-1:0]         wr_data,
    input  logic                         rd_en,
    output logic [DATA_BITS-1:0]         rd_data,
    output logic [ptr_width(DEPTH):0]    count,
    output logic                         full,
    output logic                         empty
);

    localparam int PTR_W = ptr_width(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [DATA_BITS-1:0] mem [DEPTH];
    logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]     count_q, count_d;
    logic                 wr_fire;
    logic                 rd_fire;

    // Qualify requests locally so the storage can never over- or underflow.
    assign wr_fire = wr_en & ~full;
    assign rd_fire = rd_en & ~empty;

    // Next pointer and occupancy values; simultaneous push/pop leaves count unchanged.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (wr_fire) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (rd_fire) rd_ptr_d = rd_ptr_q + PTR_W'(1);
        case ({wr_fire, rd_fire})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointer and count registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage write port; contents survive reset.
    always_ff @(posedge clk) begin
        if (wr_fire) mem[wr_ptr_q] <= wr_data;
    end

    assign rd_data = mem[rd_ptr_q];
    assign count   = count_q;
    assign full    = (count_q == CNT_W'(DEPTH));
    assign empty   = (count_q == '0);

endmodule

// File: rtl/uart_tx_fifo.sv
// Buffered byte source feeding uart_ctrl's transmit side.
// Words enter over a valid/ready handshake, are queued in uart_fifo_mem and
// drained one at a time by driving tx_data/tx_start and following tx_busy.
// Optional feature: define UART_TX_FIFO_OVF_EN to add ovf_clr/overflow, a
// sticky flag for writes attempted while the FIFO is full.
//
//   state     | meaning
//   IDLE      | waiting for a queued word and a non-busy UART; pops on launch
//   LAUNCH    | tx_start held high until the UART reports busy
//   WAIT_DONE | frame in flight; tx_data held until busy falls
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int DATA_BITS = 8,
    parameter int DEPTH     = 16
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [DATA_BITS-1:0]         wr_data,
    input  logic                         wr_valid,
    output logic                         wr_ready,
    output logic [DATA_BITS-1:0]         tx_data,
    output logic                         tx_start,
    input  logic                         tx_busy,
    output logic [ptr_width(DEPTH):0]    count,
    output logic                         empty,
    output logic                         full
`ifdef UART_TX_FIFO_OVF_EN
    ,
    input  logic                         ovf_clr,
    output logic                         overflow
`endif
);

    tx_fifo_state_t       state_q, state_d;
    logic [DATA_BITS-1:0] tx_data_q, tx_data_d;
    logic                 tx_start_q, tx_start_d;
    logic                 pop;
    logic                 wr_en;
    logic [DATA_BITS-1:0] rd_data;

    assign wr_ready = ~full;
    assign wr_en    = wr_valid & wr_ready;

    uart_fifo_mem #(
        .DATA_BITS (DATA_BITS),
        .DEPTH     (DEPTH)
    ) u_mem (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (wr_en),
        .wr_data (wr_data),
        .rd_en   (pop),
        .rd_data (rd_data),
        .count   (count),
        .full    (full),
        .empty   (empty)
    );

    // Drain FSM: next state, launch decision and output register inputs.
    always_comb begin
        state_d    = state_q;
        tx_data_d  = tx_data_q;
        tx_start_d = tx_start_q;
        pop        = 1'b0;
        case (state_q)
            IDLE: begin
                tx_start_d = 1'b0;
                if (!empty && !tx_busy) begin
                    pop        = 1'b1;
                    tx_data_d  = rd_data;
                    tx_start_d = 1'b1;
                    state_d    = LAUNCH;
                end
            end
            LAUNCH: begin
                tx_start_d = 1'b1;
                if (tx_busy) begin
                    tx_start_d = 1'b0;
                    state_d    = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                tx_start_d = 1'b0;
                if (!tx_busy) state_d = IDLE;
            end
            default: begin
                tx_start_d = 1'b0;
                state_d    = IDLE;
            end
        endcase
    end

    // FSM state and registered UART-facing outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            tx_data_q  <= '0;
            tx_start_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            tx_data_q  <= tx_data_d;
            tx_start_q <= tx_start_d;
        end
    end

    assign tx_data  = tx_data_q;
    assign tx_start = tx_start_q;

`ifdef UART_TX_FIFO_OVF_EN
    logic overflow_q, overflow_d;

    // Sticky overflow flag; a new overflow outranks a clear in the same cycle.
    always_comb begin
        overflow_d = overflow_q;
        if (ovf_clr)          overflow_d = 1'b0;
        if (wr_valid && full) overflow_d = 1'b1;
    end

    // Overflow flag register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) overflow_q <= 1'b0;
        else        overflow_q <= overflow_d;
    end

    assign overflow = overflow_q;
`endif

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo: queue-based scoreboard checked every
// cycle, a simple uart_ctrl responder, and directed literal expectations.
module tb_uart_tx_fifo;

    localparam int DATA_BITS = 8;
    localparam int DEPTH     = 16;
    localparam int CNT_W     = $clog2(DEPTH) + 1;
    localparam int FRAME     = 4;

    logic                 clk = 1'b0;
    logic                 reset;
    logic [DATA_BITS-1:0] wr_data;
    logic                 wr_valid;
    logic                 wr_ready;
    logic [DATA_BITS-1:0] tx_data;
    logic                 tx_start;
    logic                 tx_busy;
    logic [CNT_W-1:0]     count;
    logic                 empty;
    logic                 full;
`ifdef UART_TX_FIFO_OVF_EN
    logic                 ovf_clr;
    logic                 overflow;
`endif

    logic uart_en;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] exp_q[$];
    logic [7:0] got[$];
    int         launches = 0;
    logic       pend_v = 1'b0;
    logic [7:0] pend_d = 8'h00;
    logic       prev_start = 1'b0;
    logic       prev_busy  = 1'b0;
    logic [7:0] last_data  = 8'h00;

    uart_tx_fifo #(
        .DATA_BITS (DATA_BITS),
        .DEPTH     (DEPTH)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .wr_data  (wr_data),
        .wr_valid (wr_valid),
        .wr_ready (wr_ready),
        .tx_data  (tx_data),
        .tx_start (tx_start),
        .tx_busy  (tx_busy),
        .count    (count),
        .empty    (empty),
        .full     (full)
`ifdef UART_TX_FIFO_OVF_EN
        ,
        .ovf_clr  (ovf_clr),
        .overflow (overflow)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // uart_ctrl responder: sees tx_start, raises busy on the next edge, holds it FRAME cycles.
    initial begin
        forever begin
            @(negedge clk);
            if (uart_en && reset && tx_start && !tx_busy) begin
                @(posedge clk);
                #1 tx_busy = 1'b1;
                repeat (FRAME) @(posedge clk);
                #1 tx_busy = 1'b0;
            end
        end
    end

    // Scoreboard: occupancy is the queue of accepted-but-unlaunched words.
    initial begin
        forever begin
            @(negedge clk);
            if (!reset) begin
                exp_q.delete();
                pend_v     = 1'b0;
                prev_start = 1'b0;
                last_data  = 8'h00;
                prev_busy  = tx_busy;
            end else begin
                if (pend_v) exp_q.push_back(pend_d);
                pend_v = wr_valid && wr_ready;
                pend_d = wr_data;
                if (tx_start && !prev_start) begin
                    chk("launch_legal", 32'(!prev_busy && exp_q.size() > 0), 32'd1);
                    if (exp_q.size() > 0) begin
                        chk("tx_data_order", 32'(tx_data), 32'(exp_q[0]));
                        void'(exp_q.pop_front());
                    end
                    got.push_back(tx_data);
                    launches++;
                end else begin
                    chk("tx_data_stable", 32'(tx_data), 32'(last_data));
                end
                if (prev_start && prev_busy)  chk("start_drop", 32'(tx_start), 32'd0);
                if (prev_start && !prev_busy) chk("start_hold", 32'(tx_start), 32'd1);
                chk("model_count",    32'(count),    32'(exp_q.size()));
                chk("model_empty",    32'(empty),    32'(exp_q.size() == 0));
                chk("model_full",     32'(full),     32'(exp_q.size() == DEPTH));
                chk("model_wr_ready", 32'(wr_ready), 32'(exp_q.size() < DEPTH));
                prev_start = tx_start;
                prev_busy  = tx_busy;
                last_data  = tx_data;
            end
        end
    end

    task automatic write_word(input logic [7:0] d);
        int   n = 0;
        logic ok;
        wr_valid = 1'b1;
        wr_data  = d;
        do begin
            @(negedge clk);
            ok = wr_ready;
            @(posedge clk);
            #1;
            n++;
        end while (!ok && n < 1000);
        if (!ok) chk("write_timeout", 32'd0, 32'd1);
        wr_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((tx_busy || tx_start || !empty) && n < 1000) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 1000) chk("idle_timeout", 32'd0, 32'd1);
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic wait_got(input int target);
        int n = 0;
        while (got.size() < target && n < 2000) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (got.size() < target) chk("drain_timeout", 32'(got.size()), 32'(target));
    endtask

    task automatic wait_start();
        int n = 0;
        while (!tx_start && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!tx_start) chk("start_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n0;
        reset    = 1'b0;
        wr_valid = 1'b0;
        wr_data  = 8'h00;
        tx_busy  = 1'b0;
        uart_en  = 1'b1;
`ifdef UART_TX_FIFO_OVF_EN
        ovf_clr  = 1'b0;
`endif
        #1;
        chk("rst_tx_start", 32'(tx_start), 32'd0);
        chk("rst_count",    32'(count),    32'd0);
        chk("rst_empty",    32'(empty),    32'd1);
        chk("rst_full",     32'(full),     32'd0);
        chk("rst_wr_ready", 32'(wr_ready), 32'd1);
        chk("rst_tx_data",  32'(tx_data),  32'd0);
`ifdef UART_TX_FIFO_OVF_EN
        chk("rst_overflow", 32'(overflow), 32'd0);
`endif
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1;
        chk("rel_count",    32'(count),    32'd0);
        chk("rel_wr_ready", 32'(wr_ready), 32'd1);

        // Single byte: written in cycle N, launched in cycle N+2.
        wr_valid = 1'b1;
        wr_data  = 8'hA5;
        @(posedge clk);
        #1 wr_valid = 1'b0;
        chk("single_n1_count", 32'(count),    32'd1);
        chk("single_n1_start", 32'(tx_start), 32'd0);
        @(posedge clk);
        #1;
        chk("single_n2_start", 32'(tx_start), 32'd1);
        chk("single_n2_data",  32'(tx_data),  32'hA5);
        chk("single_n2_count", 32'(count),    32'd0);
        @(posedge clk);
        #1 chk("single_hold",  32'(tx_start), 32'd1);
        @(posedge clk);
        #1 chk("single_drop",  32'(tx_start), 32'd0);
        repeat (15) @(posedge clk);
        #1 chk("single_once",  32'(launches), 32'd1);
        wait_idle();

        // Burst to full while an external sender holds tx_busy.
        got.delete();
        uart_en = 1'b0;
        tx_busy = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 1; i <= 16; i++) write_word(8'(i));
        chk("burst_full",     32'(full),     32'd1);
        chk("burst_wr_ready", 32'(wr_ready), 32'd0);
        chk("burst_count",    32'(count),    32'd16);
        chk("burst_no_pop",   32'(tx_start), 32'd0);
`ifdef UART_TX_FIFO_OVF_EN
        wr_valid = 1'b1;
        wr_data  = 8'hEE;
        @(posedge clk);
        #1 wr_valid = 1'b0;
        chk("ovf_set",    32'(overflow), 32'd1);
        chk("ovf_count",  32'(count),    32'd16);
        @(posedge clk);
        #1 chk("ovf_sticky", 32'(overflow), 32'd1);
        ovf_clr = 1'b1;
        @(posedge clk);
        #1 ovf_clr = 1'b0;
        chk("ovf_clr",    32'(overflow), 32'd0);
`endif
        tx_busy = 1'b0;
        uart_en = 1'b1;
        wait_got(16);
        wait_idle();
        for (int i = 0; i < 16; i++)
            if (i < got.size()) chk("burst_order", 32'(got[i]), 32'(i + 1));
        chk("burst_empty", 32'(empty), 32'd1);

        // Pop and write on the same edge with three words queued.
        got.delete();
        uart_en = 1'b0;
        tx_busy = 1'b1;
        @(posedge clk);
        #1;
        write_word(8'h31);
        write_word(8'h32);
        write_word(8'h33);
        chk("simul_pre_count", 32'(count), 32'd3);
        wr_valid = 1'b1;
        wr_data  = 8'h34;
        tx_busy  = 1'b0;
        uart_en  = 1'b1;
        @(posedge clk);
        #1 wr_valid = 1'b0;
        chk("simul_count", 32'(count),    32'd3);
        chk("simul_start", 32'(tx_start), 32'd1);
        chk("simul_data",  32'(tx_data),  32'h31);
        wait_got(4);
        wait_idle();
        for (int i = 0; i < 4; i++)
            if (i < got.size()) chk("simul_order", 32'(got[i]), 32'h31 + 32'(i));

        // Forty words through the sixteen-entry FIFO, across pointer wrap.
        got.delete();
        for (int i = 0; i < 40; i++) write_word(8'h40 + 8'(i));
        wait_got(40);
        wait_idle();
        chk("wrap_total", 32'(got.size()), 32'd40);
        for (int i = 0; i < 40; i++)
            if (i < got.size()) chk("wrap_order", 32'(got[i]), 32'h40 + 32'(i));

        // Reset in the middle of a stream.
        for (int i = 0; i < 5; i++) write_word(8'h80 + 8'(i));
        wait_start();
        #2 reset = 1'b0;
        #1;
        chk("mid_rst_start",    32'(tx_start), 32'd0);
        chk("mid_rst_count",    32'(count),    32'd0);
        chk("mid_rst_empty",    32'(empty),    32'd1);
        chk("mid_rst_wr_ready", 32'(wr_ready), 32'd1);
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        n0 = launches;
        repeat (20) @(posedge clk);
        #1;
        chk("post_rst_launches", 32'(launches), 32'(n0));
        chk("post_rst_count",    32'(count),    32'd0);
        chk("post_rst_start",    32'(tx_start), 32'd0);
        chk("post_rst_empty",    32'(empty),    32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
